// File: rtl/llc_set_table.sv
// llc_set_table
// Tracks LLC sets that are in flight between lookup and update. A request
// allocates a slot on entry (add_valid && add_ready); the slot index
// (add_ptr) travels with the request and is released later by the update
// stage via remove_set_from_table / table_pointer_to_remove. A second
// request to a set that is already in flight is held off (add_ready=0).
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   add_valid, add_set       incoming request and its set index
//   add_ready, add_ptr       slot free and no set conflict / slot to allocate
//   lookup_set, lookup_hit   independent probe of the in-flight sets
//   remove_set_from_table,
//   table_pointer_to_remove  free one slot
//   count, full, empty       occupancy
//   remove_err               sticky: a remove hit an already-free slot
//
// ENTRIES must equal 2**PTR_W so every pointer value names a real slot.

`ifndef LLC_SET_BITS
`define LLC_SET_BITS 10
`endif

// One table slot: a valid bit plus the stored set, with the two compare
// ports the top needs (conflict check against add_set, probe against
// lookup_set).
module llc_set_entry #(
   parameter int SET_W = `LLC_SET_BITS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc,
   input  logic             free,
   input  logic [SET_W-1:0] add_set,
   input  logic [SET_W-1:0] lookup_set,
   output logic             valid,
   output logic             add_match,
   output logic             lookup_match
);

   logic [SET_W-1:0] set_q;

   // alloc and free are never both set: alloc targets only a free slot and
   // free only an occupied one.
   always_ff @(posedge clk) begin
      if (!rst)
         valid <= 1'b0;
      else if (alloc)
         valid <= 1'b1;
      else if (free)
         valid <= 1'b0;
   end

   // Set payload is only meaningful while valid, so it needs no reset.
   always_ff @(posedge clk) begin
      if (alloc)
         set_q <= add_set;
   end

   assign add_match    = valid && (set_q == add_set);
   assign lookup_match = valid && (set_q == lookup_set);

endmodule

module llc_set_table #(
   parameter int ENTRIES = 8,
   parameter int PTR_W   = 3,
   parameter int SET_W   = `LLC_SET_BITS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             add_valid,
   input  logic [SET_W-1:0] add_set,
   output logic             add_ready,
   output logic [PTR_W-1:0] add_ptr,
   input  logic [SET_W-1:0] lookup_set,
   output logic             lookup_hit,
   input  logic             remove_set_from_table,
   input  logic [PTR_W-1:0] table_pointer_to_remove,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             empty,
   output logic             remove_err
);

   logic [ENTRIES-1:0] valid;
   logic [ENTRIES-1:0] add_match;
   logic [ENTRIES-1:0] lookup_match;
   logic [ENTRIES-1:0] alloc_en;
   logic [ENTRIES-1:0] free_en;

   logic add_conflict;
   logic add_fire;
   logic remove_hit_valid;
   logic remove_fire;

   genvar g;
   generate
      for (g = 0; g < ENTRIES; g++) begin : g_entry
         assign alloc_en[g] = add_fire && (add_ptr == PTR_W'(g));
         assign free_en[g]  = remove_fire && (table_pointer_to_remove == PTR_W'(g));

         llc_set_entry #(.SET_W(SET_W)) u_entry (
            .clk          (clk),
            .rst          (rst),
            .alloc        (alloc_en[g]),
            .free         (free_en[g]),
            .add_set      (add_set),
            .lookup_set   (lookup_set),
            .valid        (valid[g]),
            .add_match    (add_match[g]),
            .lookup_match (lookup_match[g])
         );
      end
   endgenerate

   // Lowest free slot from registered valid bits. Scanning downward lets the
   // lowest index win; when no slot is free the default 0 is left in place.
   always_comb begin
      add_ptr = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!valid[i])
            add_ptr = PTR_W'(i);
      end
   end

   assign full  = (count == (PTR_W+1)'(ENTRIES));
   assign empty = (count == '0);

   // Conflict uses registered state only, so a set being removed this cycle
   // still blocks a new add of the same set until the next cycle.
   assign add_conflict = |add_match;
   assign add_ready    = !full && !add_conflict && rst;
   assign add_fire     = add_valid && add_ready;
   assign lookup_hit   = |lookup_match;

   assign remove_hit_valid = valid[table_pointer_to_remove];
   assign remove_fire      = remove_set_from_table && remove_hit_valid;

   // add_fire implies a free slot and remove_fire an occupied one, so the
   // sum stays within 0..ENTRIES.
   always_ff @(posedge clk) begin
      if (!rst)
         count <= '0;
      else
         count <= count + (PTR_W+1)'(add_fire) - (PTR_W+1)'(remove_fire);
   end

   always_ff @(posedge clk) begin
      if (!rst)
         remove_err <= 1'b0;
      else if (remove_set_from_table && !remove_hit_valid)
         remove_err <= 1'b1;
   end

endmodule

// File: tb/tb_llc_set_table.sv
module tb_llc_set_table;

   logic       clk = 1'b0;
   logic       rst;
   logic       add_valid;
   logic [9:0] add_set;
   logic       add_ready;
   logic [2:0] add_ptr;
   logic [9:0] lookup_set;
   logic       lookup_hit;
   logic       remove_set_from_table;
   logic [2:0] table_pointer_to_remove;
   logic [3:0] count;
   logic       full;
   logic       empty;
   logic       remove_err;

   llc_set_table #(.ENTRIES(8), .PTR_W(3), .SET_W(10)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .add_valid               (add_valid),
      .add_set                 (add_set),
      .add_ready               (add_ready),
      .add_ptr                 (add_ptr),
      .lookup_set              (lookup_set),
      .lookup_hit              (lookup_hit),
      .remove_set_from_table   (remove_set_from_table),
      .table_pointer_to_remove (table_pointer_to_remove),
      .count                   (count),
      .full                    (full),
      .empty                   (empty),
      .remove_err              (remove_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic       av;
      logic [9:0] as;
      logic [9:0] ls;
      logic       rm;
      logic [2:0] rp;
      logic       e_rdy;
      logic [2:0] e_ptr;
      logic       e_hit;
      logic [3:0] e_cnt;
      logic       e_full;
      logic       e_empty;
      logic       e_err;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   vidx   = 0;

   // Expected full/empty follow from the expected count by definition.
   function automatic vec_t mk(input logic r, input logic av, input logic [9:0] as,
                               input logic [9:0] ls, input logic rm, input logic [2:0] rp,
                               input logic rdy, input logic [2:0] ptr, input logic hit,
                               input logic [3:0] cnt, input logic err);
      vec_t v;
      v.r = r; v.av = av; v.as = as; v.ls = ls; v.rm = rm; v.rp = rp;
      v.e_rdy = rdy; v.e_ptr = ptr; v.e_hit = hit; v.e_cnt = cnt;
      v.e_full = (cnt == 4'd8); v.e_empty = (cnt == 4'd0); v.e_err = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %0h expected %0h", name, vidx, act, exp);
      end
   endtask

   // Drive one cycle at the falling edge, queue the expectation, then compare
   // the combinational outputs 1ns later, well before the next rising edge.
   task automatic run(input vec_t v);
      vec_t e;
      @(negedge clk);
      rst = v.r; add_valid = v.av; add_set = v.as; lookup_set = v.ls;
      remove_set_from_table = v.rm; table_pointer_to_remove = v.rp;
      sb.push_back(v);
      #1;
      e = sb.pop_front();
      chk("add_ready",  8'(add_ready),  8'(e.e_rdy));
      chk("add_ptr",    8'(add_ptr),    8'(e.e_ptr));
      chk("lookup_hit", 8'(lookup_hit), 8'(e.e_hit));
      chk("count",      8'(count),      8'(e.e_cnt));
      chk("full",       8'(full),       8'(e.e_full));
      chk("empty",      8'(empty),      8'(e.e_empty));
      chk("remove_err", 8'(remove_err), 8'(e.e_err));
      vidx++;
   endtask

   initial begin
      //            r av as      ls      rm rp  rdy ptr hit cnt err
      tbl.push_back(mk(0,1,10'h010,10'h000,0,0,  0,0,0,0,0)); // reset state
      // lowest-free allocation and lookup
      tbl.push_back(mk(1,1,10'h010,10'h020,0,0,  1,0,0,0,0));
      tbl.push_back(mk(1,1,10'h020,10'h010,0,0,  1,1,1,1,0));
      tbl.push_back(mk(1,1,10'h030,10'h020,0,0,  1,2,1,2,0));
      tbl.push_back(mk(1,0,10'h000,10'h020,0,0,  1,3,1,3,0));
      tbl.push_back(mk(1,0,10'h000,10'h040,0,0,  1,3,0,3,0));
      // conflict, held through the removing cycle, accepted after
      tbl.push_back(mk(1,1,10'h010,10'h010,0,0,  0,3,1,3,0));
      tbl.push_back(mk(1,1,10'h010,10'h010,1,0,  0,3,1,3,0));
      tbl.push_back(mk(1,1,10'h010,10'h010,0,0,  1,0,0,2,0));
      tbl.push_back(mk(1,0,10'h000,10'h010,0,0,  1,3,1,3,0));
      // simultaneous add and remove: add takes ptr 4, freed ptr 1 next
      tbl.push_back(mk(1,1,10'h040,10'h000,0,0,  1,3,0,3,0));
      tbl.push_back(mk(1,1,10'h050,10'h020,1,1,  1,4,1,4,0));
      tbl.push_back(mk(1,0,10'h060,10'h020,0,0,  1,1,0,4,0));
      tbl.push_back(mk(1,1,10'h060,10'h050,0,0,  1,1,1,4,0));
      // invalid remove: sticky error, count unchanged
      tbl.push_back(mk(1,0,10'h000,10'h000,1,6,  1,5,0,5,0));
      tbl.push_back(mk(1,1,10'h070,10'h030,1,2,  1,5,1,5,1));
      tbl.push_back(mk(1,0,10'h000,10'h030,0,0,  1,2,0,5,1));
      // invalid remove of the slot being added: add still completes
      tbl.push_back(mk(1,1,10'h080,10'h000,1,2,  1,2,0,5,1));
      tbl.push_back(mk(1,0,10'h000,10'h080,0,0,  1,6,1,6,1));
      // fill to full, remove while full, refill into freed slot
      tbl.push_back(mk(1,1,10'h090,10'h000,0,0,  1,6,0,6,1));
      tbl.push_back(mk(1,1,10'h0A0,10'h000,0,0,  1,7,0,7,1));
      tbl.push_back(mk(1,1,10'h0B0,10'h0A0,0,0,  0,0,1,8,1));
      tbl.push_back(mk(1,1,10'h0B0,10'h070,1,5,  0,0,1,8,1));
      tbl.push_back(mk(1,1,10'h0B0,10'h070,0,0,  1,5,0,7,1));
      tbl.push_back(mk(1,0,10'h000,10'h0B0,0,0,  0,0,1,8,1));
      // reset mid-operation with add_valid high
      tbl.push_back(mk(0,1,10'h0C0,10'h010,0,0,  0,0,1,8,1));
      tbl.push_back(mk(1,0,10'h000,10'h010,0,0,  1,0,0,0,0));

      // First cycle brings state out of X; nothing is checked here.
      @(negedge clk);
      rst = 1'b0; add_valid = 1'b0; add_set = '0; lookup_set = '0;
      remove_set_from_table = 1'b0; table_pointer_to_remove = '0;

      for (int i = 0; i < tbl.size(); i++)
         run(tbl[i]);

      // Hand sequence: fill from empty, then drain in order.
      for (int i = 0; i < 8; i++)
         run(mk(1, 1, 10'h100 + 10'(i), 10'h100 + 10'(i), 0, 0,
                1, 3'(i), 0, 4'(i), 0));
      run(mk(1, 1, 10'h1FF, 10'h103, 0, 0,  0, 0, 1, 8, 0));
      for (int i = 0; i < 8; i++)
         run(mk(1, 0, 10'h3FF, 10'h100 + 10'(i), 1, 3'(i),
                (i != 0), 0, 1, 4'(8 - i), 0));
      run(mk(1, 0, 10'h000, 10'h100, 0, 0,  1, 0, 0, 0, 0));
      // Stale remove after the drain flags the error one cycle later.
      run(mk(1, 0, 10'h000, 10'h000, 1, 3,  1, 0, 0, 0, 0));
      run(mk(1, 0, 10'h000, 10'h000, 0, 0,  1, 0, 0, 0, 1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
